// File: rtl/ibus_sram_resp_pkg.sv
// Shared instruction-bus types and constants for the fetch SRAM responder.
package ibus_sram_resp_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 32;

    // RISC-V canonical NOP (addi x0, x0, 0), returned for rejected fetches
    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/ibus_sram_resp.sv
// Fixed-latency instruction-fetch responder in front of an external synchronous SRAM.
// Optional feature macro: IBUS_SRAM_CHECK_EN (alignment/range check, sticky err port).
module ibus_sram_resp
    import ibus_sram_resp_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [63:0] BASE      = 64'h8000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  ibus_req_t                    ireq,
    output ibus_resp_t                   iresp,
    output logic                         mem_en,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
`ifdef IBUS_SRAM_CHECK_EN
    output logic                         err,
`endif
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MEM_AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cap_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  cap_data;
    logic               accept;
    logic               legal;

    assign accept = (state_q == IDLE) && ireq.valid && !reset;

`ifdef IBUS_SRAM_CHECK_EN
    logic [ADDR_W-1:0] offset;
    logic              bad_q;
    logic              err_q;

    // Offset compare doubles as the lower bound: addresses below BASE wrap to huge values
    assign offset = ireq.addr - BASE;
    assign legal  = (ireq.addr[1:0] == 2'b00) && (offset < ADDR_W'(4 * MEM_WORDS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            bad_q <= !legal;
            err_q <= err_q | !legal;
        end
    end

    assign err      = err_q;
    assign cap_data = bad_q ? NOP : mem_rdata;
`else
    assign legal    = 1'b1;
    assign cap_data = mem_rdata;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and latency down-counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ireq.valid) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter and read-data capture; cap_q marks the cycle SRAM data is valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            cap_q  <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            cap_q <= accept;
            if (cap_q) begin
                data_q <= cap_data;
            end
        end
    end

    // Outputs; with LATENCY=1 the data_ok cycle is also the capture cycle, so bypass the register
    always_comb begin
        iresp         = '0;
        mem_en        = 1'b0;
        mem_addr      = '0;
        iresp.addr_ok = accept;
        iresp.data_ok = (state_q == DONE);
        iresp.data    = (cap_q && (state_q == DONE)) ? cap_data : data_q;
        if (accept && legal) begin
            mem_en   = 1'b1;
            mem_addr = MEM_AW'((ireq.addr - BASE) >> 2);
        end
    end

endmodule

// File: tb/tb_ibus_sram_resp.sv
// Bench for ibus_sram_resp: LATENCY=2 and LATENCY=1 instances against a per-cycle transaction model.
module tb_ibus_sram_resp;
    import ibus_sram_resp_pkg::*;

    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned MEM_AW    = 12;
    localparam logic [63:0] BASE      = 64'h8000_0000;

    logic              clk = 1'b0;
    logic              reset;
    ibus_req_t         req      [2];
    ibus_resp_t        resp     [2];
    logic              mem_en_w [2];
    logic [MEM_AW-1:0] mem_addr_w [2];
    logic [31:0]       rdata    [2];
`ifdef IBUS_SRAM_CHECK_EN
    logic              err_w    [2];
`endif
    logic [31:0]       mem      [MEM_WORDS];

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;

    // model state: cycles left until data_ok (0 = idle), data due, last returned data, sticky error
    int          remain [2];
    logic [31:0] exp_d  [2];
    logic [31:0] last_d [2];
    logic        err_m  [2];

    always #5 clk = ~clk;

    ibus_sram_resp #(.LATENCY(2), .MEM_WORDS(MEM_WORDS), .BASE(BASE)) u_dut_l2 (
        .clk       (clk),
        .reset     (reset),
        .ireq      (req[0]),
        .iresp     (resp[0]),
        .mem_en    (mem_en_w[0]),
        .mem_addr  (mem_addr_w[0]),
`ifdef IBUS_SRAM_CHECK_EN
        .err       (err_w[0]),
`endif
        .mem_rdata (rdata[0])
    );

    ibus_sram_resp #(.LATENCY(1), .MEM_WORDS(MEM_WORDS), .BASE(BASE)) u_dut_l1 (
        .clk       (clk),
        .reset     (reset),
        .ireq      (req[1]),
        .iresp     (resp[1]),
        .mem_en    (mem_en_w[1]),
        .mem_addr  (mem_addr_w[1]),
`ifdef IBUS_SRAM_CHECK_EN
        .err       (err_w[1]),
`endif
        .mem_rdata (rdata[1])
    );

    // Synchronous SRAM: data appears the cycle after the strobe
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en_w[k]) rdata[k] <= mem[mem_addr_w[k]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[lat%0d] t=%0t got %h expected %h", tag, 2 - cur_k, $time, got, exp);
        end
    endtask

    task automatic model_step(input int k, input int lat);
        logic              legal;
        logic [63:0]       off;
        logic [MEM_AW-1:0] idx;
        cur_k = k;
        off   = req[k].addr - BASE;
        idx   = MEM_AW'(off >> 2);
`ifdef IBUS_SRAM_CHECK_EN
        legal = (req[k].addr[1:0] == 2'b00) && (off < 64'(4 * MEM_WORDS));
`else
        legal = 1'b1;
`endif
        if (reset) begin
            check("rst_addr_ok",  64'(resp[k].addr_ok), 64'd0);
            check("rst_data_ok",  64'(resp[k].data_ok), 64'd0);
            check("rst_data",     64'(resp[k].data),    64'd0);
            check("rst_mem_en",   64'(mem_en_w[k]),     64'd0);
            check("rst_mem_addr", 64'(mem_addr_w[k]),   64'd0);
`ifdef IBUS_SRAM_CHECK_EN
            check("rst_err",      64'(err_w[k]),        64'd0);
`endif
            remain[k] = 0;
            last_d[k] = '0;
            err_m[k]  = 1'b0;
        end else begin
`ifdef IBUS_SRAM_CHECK_EN
            check("err", 64'(err_w[k]), 64'(err_m[k]));
`endif
            if (remain[k] == 0) begin
                check("addr_ok", 64'(resp[k].addr_ok), 64'(req[k].valid));
                check("data_ok_idle", 64'(resp[k].data_ok), 64'd0);
                check("data_hold", 64'(resp[k].data), 64'(last_d[k]));
                check("mem_en", 64'(mem_en_w[k]), 64'(req[k].valid && legal));
                if (req[k].valid) begin
                    if (legal) check("mem_addr", 64'(mem_addr_w[k]), 64'(idx));
                    exp_d[k]  = legal ? mem[idx] : NOP;
                    err_m[k]  = err_m[k] | !legal;
                    remain[k] = lat;
                end
            end else begin
                check("addr_ok_busy", 64'(resp[k].addr_ok), 64'd0);
                check("mem_en_busy", 64'(mem_en_w[k]), 64'd0);
                remain[k]--;
                check("data_ok", 64'(resp[k].data_ok), 64'(remain[k] == 0));
                if (remain[k] == 0) begin
                    check("data", 64'(resp[k].data), 64'(exp_d[k]));
                    last_d[k] = exp_d[k];
                end
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 2);
        model_step(1, 1);
    end

    task automatic drive(input logic v, input logic [63:0] a, input int n);
        for (int k = 0; k < 2; k++) begin
            req[k].valid = v;
            req[k].addr  = a;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned sel;
        logic [63:0] word;
        sel  = $urandom_range(0, 9);
        word = 64'($urandom_range(0, MEM_WORDS - 1)) * 64'd4;
        if (sel < 7) return BASE + word;
        if (sel == 7) return BASE + word + 64'($urandom_range(1, 3));
        return {$urandom, $urandom};
    endfunction

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0093;
        for (int k = 0; k < 2; k++) begin
            req[k]    = '0;
            remain[k] = 0;
            exp_d[k]  = '0;
            last_d[k] = '0;
            err_m[k]  = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // accept in the first cycle after reset, word 0, valid dropped and addr changed while busy
        reset = 1'b0;
        drive(1'b1, BASE, 1);
        drive(1'b0, 64'h0, 4);
        // held valid: back-to-back acceptance at the throughput limit
        drive(1'b1, BASE + 64'd4, 3);
        drive(1'b1, BASE + 64'd8, 3);
        drive(1'b0, 64'h0, 3);
        // reset one cycle after acceptance aborts; request accepted right after deassertion
        drive(1'b1, BASE + 64'd12, 1);
        reset = 1'b1;
        drive(1'b1, BASE + 64'd16, 1);
        reset = 1'b0;
        drive(1'b1, BASE + 64'd16, 1);
        drive(1'b0, 64'h0, 4);
        // misaligned fetch: NOP with normal timing (and err when checking is built in)
        drive(1'b1, BASE + 64'd2, 1);
        drive(1'b0, 64'h0, 5);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                req[k].valid = ($urandom_range(0, 2) != 0);
                req[k].addr  = rand_addr();
            end
            @(posedge clk);
            #1;
        end

        reset = 1'b0;
        drive(1'b0, 64'h0, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibus_sram_resp.md
IBUS_SRAM_RESP -- requirements
Module: ibus_sram_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from request acceptance to data_ok; legal range 1..15.
REQ-002 SHALL have parameter MEM_WORDS, default 4096: 32-bit words in the backing SRAM, power of two.
REQ-003 SHALL have parameter BASE, default 64'h8000_0000: byte address of SRAM word 0.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port ireq, input, ibus_req_t: fetch request; fields valid and 64-bit addr.
REQ-007 SHALL have port iresp, output, ibus_resp_t: response; fields addr_ok, data_ok and 32-bit data.
REQ-008 SHALL have port mem_en, output, 1: SRAM read strobe.
REQ-009 SHALL have port mem_addr, output, $clog2(MEM_WORDS): SRAM word index.
REQ-010 SHALL have port mem_rdata, input, 32: SRAM read data, valid the cycle after mem_en.
REQ-011 SHALL have port err, output, 1: sticky illegal-access flag, present only with IBUS_SRAM_CHECK_EN.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-013 In IDLE with ireq.valid=1, SHALL assert iresp.addr_ok combinationally, pulse mem_en, latch addr and go to WAIT; this is the accept cycle T.
REQ-014 SHALL drive iresp.addr_ok=0 in WAIT and DONE; requests presented there are not accepted.
REQ-015 SHALL drive mem_addr as (addr-BASE)>>2, truncated to $clog2(MEM_WORDS) bits, so out-of-range addresses wrap.
REQ-016 SHALL capture mem_rdata into the data register at cycle T+1.
REQ-017 SHALL assert iresp.data_ok as a single-cycle pulse at cycle T+LATENCY, which is the DONE state; with LATENCY=1, WAIT is skipped.
REQ-018 SHALL count latency with a down-counter loaded with LATENCY-1 at accept.
REQ-019 SHALL hold iresp.data stable from the data_ok cycle until the next data_ok.
REQ-020 SHALL return to IDLE after DONE; maximum throughput is one request per LATENCY+1 cycles.
REQ-021 Once a request is accepted, SHALL complete it even if ireq.valid or ireq.addr changes.
REQ-022 SHALL ignore ireq.addr[1:0] unless IBUS_SRAM_CHECK_EN is defined.

Reset
REQ-023 On reset assertion, SHALL asynchronously force state=IDLE, counter=0, data=0, addr_ok=0, data_ok=0, mem_en=0, mem_addr=0, err=0.
REQ-024 Reset asserted mid-transaction SHALL abort it with no data_ok; the first acceptance SHALL be possible in the first cycle after deassertion.

Configuration
REQ-025 With IBUS_SRAM_CHECK_EN defined, a request with addr[1:0]!=0 or addr outside [BASE, BASE+4*MEM_WORDS) SHALL be accepted without mem_en, SHALL respond with normal timing and data=32'h0000_0013 (NOP), and SHALL set err until reset.
REQ-026 Without IBUS_SRAM_CHECK_EN, SHALL omit the err port and the check logic and SHALL apply REQ-015/REQ-022 wrap behaviour.

Structure
REQ-027 ibus_req_t, ibus_resp_t and the NOP constant SHALL come from the shared pipes/common packages; the FSM state enum SHALL stay local.
REQ-028 SHALL be a single module with no sub-module; the SRAM is external and the bench models it.

Verification
REQ-029 Bench SHALL check: LATENCY=2, valid at addr 0x8000_0000 with SRAM[0]=0x0000_0093 -> addr_ok at T, mem_en at T, mem_addr=0, data_ok at T+2 with data 0x0000_0093.
REQ-030 Bench SHALL check: back-to-back valid at 0x8000_0004 then 0x8000_0008, LATENCY=2 -> second acceptance at T+3, data_ok pulses at T+2 and T+5.
REQ-031 Bench SHALL check: LATENCY=1, held valid -> data_ok at T+1; next acceptance at T+2.
REQ-032 Bench SHALL check: valid dropped at T+1 -> data_ok still at T+LATENCY with the originally addressed word.
REQ-033 Bench SHALL check: reset pulse at T+1 -> no data_ok and all outputs 0; a new request is accepted the cycle after reset deasserts.
REQ-034 Bench SHALL check, with IBUS_SRAM_CHECK_EN: addr 0x8000_0002 -> no mem_en, data 0x0000_0013 at T+LATENCY, err=1 held until reset.
